// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: opcodes, ALU codes, mux selects,
// instruction classes and control sequencer state encoding.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JALR   = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_DECODE     = 3'd2,
        S_EXECUTE    = 3'd3,
        S_MEM        = 3'd4,
        S_WRITEBACK  = 3'd5,
        S_TRAP       = 3'd6,
        S_HALT       = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_FENCE,
        CL_SYSTEM, CL_JAL, CL_JALR, CL_LUI
    } iclass_t;

    // alt selects SUB/SRA (inst[30]) where the encoding allows it
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3,
                                               input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I decoder: ALU control, writeback select,
// instruction class and illegal-opcode flag.
module ctrl_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] inst,
    output logic [3:0]  alu_op,
    output logic        alu_src_b,
    output logic [1:0]  wb_sel,
    output iclass_t     iclass,
    output logic        illegal
);

    logic [2:0] f3;
    logic       unused;

    assign f3     = inst[14:12];
    assign unused = ^{inst[31], inst[29:15], inst[11:7]};

    always_comb begin
        alu_op    = ALU_ADD;
        alu_src_b = 1'b1;
        wb_sel    = WB_ALU;
        iclass    = CL_ALU;
        illegal   = 1'b0;
        case (inst[6:0])
            OPC_OP_IMM: alu_op = alu_from_f3(f3, f3 == 3'd5 && inst[30]);
            OPC_OP: begin
                alu_src_b = 1'b0;
                alu_op    = alu_from_f3(f3, (f3 == 3'd0 || f3 == 3'd5)
                                            && inst[30]);
            end
            OPC_LUI: begin
                wb_sel = WB_IMM;
                iclass = CL_LUI;
            end
            OPC_AUIPC: iclass = CL_ALU;
            OPC_JAL: begin
                wb_sel = WB_PC4;
                iclass = CL_JAL;
            end
            OPC_JALR: begin
                wb_sel = WB_PC4;
                iclass = CL_JALR;
            end
            OPC_BRANCH: begin
                alu_src_b = 1'b0;
                alu_op    = ALU_SUB;
                iclass    = CL_BRANCH;
            end
            OPC_LOAD: begin
                wb_sel = WB_LOAD;
                iclass = CL_LOAD;
            end
            OPC_STORE:  iclass = CL_STORE;
            OPC_FENCE:  iclass = CL_FENCE;
            OPC_SYSTEM: iclass = CL_SYSTEM;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: owns the instruction
// register and steps fetch/decode/execute/mem/writeback.
module ctrl_fsm
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_INST  = 32'h00000013,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_data,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic [31:0] inst,
    output logic        imem_req,
    output logic        regwr,
    output logic [3:0]  alu_op,
    output logic        alu_src_b,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        trap,
    output logic        halted
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    d_alu;
    logic          d_src;
    logic [1:0]    d_wb;
    iclass_t       d_cls;
    logic          d_ill;
    logic          timeout;

    ctrl_decode u_dec (
        .inst      (inst),
        .alu_op    (d_alu),
        .alu_src_b (d_src),
        .wb_sel    (d_wb),
        .iclass    (d_cls),
        .illegal   (d_ill)
    );

    // last permitted MEM cycle is the one where cnt == MEM_TIMEOUT-1
    assign timeout = (cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            inst   <= RESET_INST;
            cnt    <= '0;
            trap   <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_FETCH: state <= S_FETCH_WAIT;
                S_FETCH_WAIT: begin
                    inst  <= imem_data;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (d_ill) begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                    end else if (d_cls == CL_SYSTEM) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    cnt <= '0;
                    case (d_cls)
                        CL_LOAD, CL_STORE:   state <= S_MEM;
                        CL_BRANCH, CL_FENCE: state <= S_FETCH;
                        default:             state <= S_WRITEBACK;
                    endcase
                end
                S_MEM: begin
                    cnt <= cnt + 1'b1;
                    if (dmem_ready) begin
                        state <= (d_cls == CL_LOAD) ? S_WRITEBACK : S_FETCH;
                    end else if (timeout) begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                    end
                end
                S_WRITEBACK: state <= S_FETCH;
                default:     state <= state;
            endcase
        end
    end

    always_comb begin
        imem_req  = (state == S_FETCH);
        regwr     = 1'b0;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        wb_sel    = WB_ALU;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        if (state == S_EXECUTE || state == S_MEM || state == S_WRITEBACK) begin
            alu_op    = d_alu;
            alu_src_b = d_src;
        end
        case (state)
            S_EXECUTE: begin
                if (d_cls == CL_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                end else if (d_cls == CL_FENCE) begin
                    pc_we = 1'b1;
                end
            end
            S_MEM: begin
                dmem_re = (d_cls == CL_LOAD);
                dmem_we = (d_cls == CL_STORE);
                pc_we   = dmem_ready && (d_cls == CL_STORE);
            end
            S_WRITEBACK: begin
                regwr  = 1'b1;
                pc_we  = 1'b1;
                wb_sel = d_wb;
                if (d_cls == CL_JAL)
                    pc_sel = PC_SEL_BRANCH;
                else if (d_cls == CL_JALR)
                    pc_sel = PC_SEL_JALR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: driver queues per-cycle expected
// outputs, monitor compares them on the falling edge.
module tb_ctrl_fsm;

    typedef struct packed {
        logic [31:0] inst;
        logic        req;
        logic        rw;
        logic [3:0]  alu;
        logic        sb;
        logic        re;
        logic        we;
        logic [1:0]  wb;
        logic        pwe;
        logic [1:0]  ps;
        logic        tr;
        logic        hl;
    } out_t;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] LW    = 32'h0000A103;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] JAL   = 32'h008000EF;
    localparam logic [31:0] LUI   = 32'h123450B7;
    localparam logic [31:0] SW    = 32'h0020A023;
    localparam logic [31:0] ILL   = 32'hFFFFFFFF;
    localparam logic [31:0] EBRK  = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_data = '0;
    logic        dmem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] inst;
    logic        imem_req, regwr, alu_src_b, dmem_re, dmem_we;
    logic        pc_we, trap, halted;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel, pc_sel;

    out_t  act;
    out_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    ctrl_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .imem_data    (imem_data),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .inst         (inst),
        .imem_req     (imem_req),
        .regwr        (regwr),
        .alu_op       (alu_op),
        .alu_src_b    (alu_src_b),
        .dmem_re      (dmem_re),
        .dmem_we      (dmem_we),
        .wb_sel       (wb_sel),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .trap         (trap),
        .halted       (halted)
    );

    always_comb act = '{inst, imem_req, regwr, alu_op, alu_src_b, dmem_re,
                        dmem_we, wb_sel, pc_we, pc_sel, trap, halted};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got %h want %h", n, act, e);
            end
        end
    end

    function automatic out_t mk(
        input logic [31:0] i, input logic req, input logic rw,
        input logic [3:0] alu, input logic sb, input logic re,
        input logic we, input logic [1:0] wb, input logic pwe,
        input logic [1:0] ps, input logic tr, input logic hl);
        return '{i, req, rw, alu, sb, re, we, wb, pwe, ps, tr, hl};
    endfunction

    function automatic out_t idle(input logic [31:0] i);
        return mk(i, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic cyc(input out_t e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch3(input logic [31:0] prev, input logic [31:0] ni);
        imem_data = ni;
        cyc(mk(prev, 1, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0), "fetch");
        cyc(idle(prev), "fetch_wait");
        cyc(idle(ni), "decode");
    endtask

    task automatic reset_cycle(input out_t during);
        rst = 1'b1;
        cyc(during, "rst_cycle");
        rst = 1'b0;
    endtask

    // store: EXECUTE then MEM, ready raised on MEM cycle rdy (0 = never)
    task automatic store_seq(input int cycles, input int rdy);
        cyc(mk(SW, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0, 0), "sw_exec");
        for (int k = 1; k <= cycles; k++) begin
            dmem_ready = (k == rdy);
            cyc(mk(SW, 0, 0, ADD, 1, 0, 1, 0, dmem_ready, 0, 0, 0),
                "sw_mem");
        end
        dmem_ready = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        fetch3(NOP, ADDI);
        cyc(mk(ADDI, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0, 0), "addi_exec");
        cyc(mk(ADDI, 0, 1, ADD, 1, 0, 0, 0, 1, 0, 0, 0), "addi_wb");

        fetch3(ADDI, LW);
        cyc(mk(LW, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0, 0), "lw_exec");
        for (int k = 1; k <= 3; k++) begin
            dmem_ready = (k == 3);
            cyc(mk(LW, 0, 0, ADD, 1, 1, 0, 0, 0, 0, 0, 0), "lw_mem");
        end
        dmem_ready = 1'b0;
        cyc(mk(LW, 0, 1, ADD, 1, 0, 0, 1, 1, 0, 0, 0), "lw_wb");

        fetch3(LW, BEQ);
        branch_taken = 1'b1;
        cyc(mk(BEQ, 0, 0, SUB, 0, 0, 0, 0, 1, 1, 0, 0), "beq_taken");
        branch_taken = 1'b0;
        fetch3(BEQ, BEQ);
        cyc(mk(BEQ, 0, 0, SUB, 0, 0, 0, 0, 1, 0, 0, 0), "beq_not_taken");

        fetch3(BEQ, JAL);
        cyc(mk(JAL, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0, 0), "jal_exec");
        cyc(mk(JAL, 0, 1, ADD, 1, 0, 0, 2, 1, 1, 0, 0), "jal_wb");

        fetch3(JAL, LUI);
        cyc(mk(LUI, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0, 0), "lui_exec");
        cyc(mk(LUI, 0, 1, ADD, 1, 0, 0, 3, 1, 0, 0, 0), "lui_wb");

        fetch3(LUI, SW);
        store_seq(1, 1);
        fetch3(SW, SW);
        store_seq(255, 255);

        fetch3(SW, SW);
        store_seq(255, 0);
        for (int k = 0; k < 3; k++)
            cyc(mk(SW, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 1, 0), "sw_timeout_trap");
        reset_cycle(mk(SW, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 1, 0));

        fetch3(NOP, SW);
        store_seq(9, 0);
        reset_cycle(mk(SW, 0, 0, ADD, 1, 0, 1, 0, 0, 0, 0, 0));

        fetch3(NOP, ILL);
        for (int k = 0; k < 20; k++)
            cyc(mk(ILL, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 1, 0), "ill_trap");
        reset_cycle(mk(ILL, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 1, 0));

        fetch3(NOP, EBRK);
        for (int k = 0; k < 10; k++)
            cyc(mk(EBRK, 0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 1), "halt");

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
